// File: rtl/rv_mdu_arbiter.sv
// rv_mdu_arbiter
// Shares a single rv_mdu between NREQ requesters. An idle arbiter picks a
// requester round-robin, latches its operands, drives them to the MDU until
// the MDU stops stalling, captures the result and returns it to the winner
// with a one-cycle response pulse. A kill from the owner aborts the
// in-flight operation through mdu_kill_o.
//
// XLEN and MDU_OP_W default to the widths used by rv_pkg / rv_mdu_pkg
// (32-bit data, 3-bit funct3-style opcode); override them when the
// arbiter is instantiated next to a differently sized MDU.
//
// Ports
//   clk_i, arstn_i      clock, asynchronous active-low reset
//   req_valid_i         per-requester operation pending
//   req_ready_o         one-hot accept pulse (combinational, IDLE only)
//   req_a_i/req_b_i     packed operands, slice i = [i*XLEN +: XLEN]
//   req_op_i            packed opcodes, slice i = [i*MDU_OP_W +: MDU_OP_W]
//   req_kill_i          per-requester cancel
//   resp_valid_o        one-hot response pulse
//   resp_result_o       shared result bus (qualified by resp_valid_o)
//   mdu_*_o / mdu_*_i   connection to rv_mdu
//   busy_o              arbiter is not idle
module rv_mdu_arbiter #(
  parameter int XLEN     = 32,
  parameter int MDU_OP_W = 3,
  parameter int NREQ     = 2
) (
  input  logic                     clk_i,
  input  logic                     arstn_i,
  input  logic [NREQ-1:0]          req_valid_i,
  output logic [NREQ-1:0]          req_ready_o,
  input  logic [NREQ*XLEN-1:0]     req_a_i,
  input  logic [NREQ*XLEN-1:0]     req_b_i,
  input  logic [NREQ*MDU_OP_W-1:0] req_op_i,
  input  logic [NREQ-1:0]          req_kill_i,
  output logic [NREQ-1:0]          resp_valid_o,
  output logic [XLEN-1:0]          resp_result_o,
  output logic                     mdu_req_o,
  output logic [XLEN-1:0]          mdu_port_a_o,
  output logic [XLEN-1:0]          mdu_port_b_o,
  output logic [MDU_OP_W-1:0]      mdu_op_o,
  output logic                     mdu_kill_o,
  output logic                     mdu_keep_o,
  input  logic [XLEN-1:0]          mdu_result_i,
  input  logic                     mdu_stall_i,
  output logic                     busy_o
);

  localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t              state_reg, state_next;
  logic [OW-1:0]       owner_reg, owner_next;
  logic [OW-1:0]       rr_ptr_reg, rr_ptr_next;
  logic [XLEN-1:0]     a_reg, a_next;
  logic [XLEN-1:0]     b_reg, b_next;
  logic [MDU_OP_W-1:0] op_reg, op_next;
  logic [XLEN-1:0]     res_reg, res_next;

  // Unpacked views of the packed requester buses.
  logic [XLEN-1:0]     a_arr  [NREQ];
  logic [XLEN-1:0]     b_arr  [NREQ];
  logic [MDU_OP_W-1:0] op_arr [NREQ];
  logic [NREQ-1:0]     eligible;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign a_arr[gi]    = req_a_i[gi*XLEN +: XLEN];
    assign b_arr[gi]    = req_b_i[gi*XLEN +: XLEN];
    assign op_arr[gi]   = req_op_i[gi*MDU_OP_W +: MDU_OP_W];
    assign eligible[gi] = req_valid_i[gi] & ~req_kill_i[gi];
  end

  // Round-robin search: scan offsets from the highest down so that the
  // eligible index closest to rr_ptr (smallest offset) is the last writer.
  logic [OW-1:0] win;
  logic          found;

  always_comb begin
    logic [OW-1:0] cand;
    win   = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = OW'((int'(rr_ptr_reg) + k) % NREQ);
      if (eligible[cand]) begin
        win   = cand;
        found = 1'b1;
      end
    end
  end

  // Pointer moves to the slot after the owner once its operation retires.
  logic [OW-1:0] owner_inc;
  assign owner_inc = (owner_reg == OW'(NREQ - 1)) ? '0 : owner_reg + OW'(1);

  always_comb begin
    state_next   = state_reg;
    owner_next   = owner_reg;
    rr_ptr_next  = rr_ptr_reg;
    a_next       = a_reg;
    b_next       = b_reg;
    op_next      = op_reg;
    res_next     = res_reg;
    req_ready_o  = '0;
    resp_valid_o = '0;
    mdu_req_o    = 1'b0;
    mdu_kill_o   = 1'b0;

    case (state_reg)
      IDLE: begin
        // Gating with arstn_i keeps ready low while reset is asserted.
        if (found && arstn_i) begin
          req_ready_o = NREQ'(1) << win;
          a_next      = a_arr[win];
          b_next      = b_arr[win];
          op_next     = op_arr[win];
          owner_next  = win;
          state_next  = BUSY;
        end
      end
      BUSY: begin
        mdu_req_o = 1'b1;
        // Kill wins over a completion arriving in the same cycle.
        if (req_kill_i[owner_reg]) begin
          mdu_kill_o  = 1'b1;
          rr_ptr_next = owner_inc;
          state_next  = IDLE;
        end else if (!mdu_stall_i) begin
          res_next   = mdu_result_i;
          state_next = RESP;
        end
      end
      RESP: begin
        resp_valid_o = NREQ'(1) << owner_reg;
        rr_ptr_next  = owner_inc;
        state_next   = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_reg  <= IDLE;
      owner_reg  <= '0;
      rr_ptr_reg <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      op_reg     <= '0;
      res_reg    <= '0;
    end else begin
      state_reg  <= state_next;
      owner_reg  <= owner_next;
      rr_ptr_reg <= rr_ptr_next;
      a_reg      <= a_next;
      b_reg      <= b_next;
      op_reg     <= op_next;
      res_reg    <= res_next;
    end
  end

  // MDU operands come only from the latches, never straight from requesters.
  assign mdu_port_a_o  = a_reg;
  assign mdu_port_b_o  = b_reg;
  assign mdu_op_o      = op_reg;
  assign mdu_keep_o    = 1'b0;
  assign resp_result_o = res_reg;
  assign busy_o        = (state_reg != IDLE);

endmodule

// File: tb/tb_rv_mdu_arbiter.sv
// Directed testbench for rv_mdu_arbiter (NREQ=2, XLEN=32, 3-bit opcodes).
// The bench plays the MDU itself by driving mdu_stall_i / mdu_result_i.
module tb_rv_mdu_arbiter;
  localparam int XLEN = 32;
  localparam int OPW  = 3;
  localparam int NREQ = 2;
  localparam logic [OPW-1:0] MDU_MUL  = 3'd0;
  localparam logic [OPW-1:0] MDU_DIVU = 3'd5;

  logic                 clk_i = 1'b0;
  logic                 arstn_i;
  logic [NREQ-1:0]      req_valid_i;
  logic [NREQ-1:0]      req_ready_o;
  logic [NREQ*XLEN-1:0] req_a_i, req_b_i;
  logic [NREQ*OPW-1:0]  req_op_i;
  logic [NREQ-1:0]      req_kill_i;
  logic [NREQ-1:0]      resp_valid_o;
  logic [XLEN-1:0]      resp_result_o;
  logic                 mdu_req_o;
  logic [XLEN-1:0]      mdu_port_a_o, mdu_port_b_o;
  logic [OPW-1:0]       mdu_op_o;
  logic                 mdu_kill_o, mdu_keep_o;
  logic [XLEN-1:0]      mdu_result_i;
  logic                 mdu_stall_i;
  logic                 busy_o;

  int checks   = 0;
  int failures = 0;

  rv_mdu_arbiter #(.XLEN(XLEN), .MDU_OP_W(OPW), .NREQ(NREQ)) dut (
    .clk_i(clk_i), .arstn_i(arstn_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_a_i(req_a_i), .req_b_i(req_b_i), .req_op_i(req_op_i),
    .req_kill_i(req_kill_i),
    .resp_valid_o(resp_valid_o), .resp_result_o(resp_result_o),
    .mdu_req_o(mdu_req_o), .mdu_port_a_o(mdu_port_a_o),
    .mdu_port_b_o(mdu_port_b_o), .mdu_op_o(mdu_op_o),
    .mdu_kill_o(mdu_kill_o), .mdu_keep_o(mdu_keep_o),
    .mdu_result_i(mdu_result_i), .mdu_stall_i(mdu_stall_i),
    .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Land just after the active edge; inputs change here, checks follow settle.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_req(input int i, input logic [XLEN-1:0] a,
                         input logic [XLEN-1:0] b, input logic [OPW-1:0] op);
    req_a_i[i*XLEN +: XLEN] = a;
    req_b_i[i*XLEN +: XLEN] = b;
    req_op_i[i*OPW +: OPW]  = op;
  endtask

  initial begin
    arstn_i      = 1'b0;
    req_valid_i  = 2'b01;
    req_a_i      = '0;
    req_b_i      = '0;
    req_op_i     = '0;
    req_kill_i   = '0;
    mdu_result_i = '0;
    mdu_stall_i  = 1'b0;

    // ---------------- reset state ----------------
    settle();
    chk("rst_ready", req_ready_o, 2'b00);
    chk("rst_outs", {busy_o, mdu_req_o, mdu_kill_o, mdu_keep_o, resp_valid_o}, 6'd0);
    chk("rst_data", {resp_result_o, mdu_port_a_o, mdu_port_b_o, mdu_op_o}, '0);
    req_valid_i = '0;
    tick();
    tick();
    arstn_i = 1'b1;
    settle();
    chk("post_rst_busy", busy_o, 1'b0);
    $display("txn reset done");

    // ---------------- single multiply ----------------
    tick();
    set_req(0, 32'd7, 32'd6, MDU_MUL);
    req_valid_i = 2'b01;
    settle();
    chk("mul_ready_T", req_ready_o, 2'b01);
    tick();                                   // T+1
    req_valid_i  = 2'b00;
    mdu_result_i = 32'd42;
    settle();
    chk("mul_port_T1", {mdu_req_o, mdu_port_a_o, mdu_port_b_o, mdu_op_o},
        {1'b1, 32'd7, 32'd6, MDU_MUL});
    chk("mul_noresp_T1", resp_valid_o, 2'b00);
    tick();                                   // T+2
    mdu_result_i = 32'd0;
    settle();
    chk("mul_resp_T2", {resp_valid_o, resp_result_o, mdu_req_o}, {2'b01, 32'd42, 1'b0});
    tick();                                   // T+3
    settle();
    chk("mul_idle_T3", {busy_o, resp_valid_o}, 3'b000);
    $display("txn mul req0 7*6 -> %0d", resp_result_o);

    // ---------------- divide with 32 stall cycles ----------------
    set_req(1, 32'd100, 32'd7, MDU_DIVU);
    req_valid_i = 2'b10;
    mdu_stall_i = 1'b1;
    settle();
    chk("div_ready_T", req_ready_o, 2'b10);
    tick();
    req_valid_i = 2'b00;
    set_req(1, 32'hDEAD, 32'hBEEF, MDU_MUL);   // requester changes; port must not
    for (int c = 0; c < 32; c++) begin
      settle();
      chk("div_stable", {mdu_req_o, mdu_port_a_o, mdu_port_b_o, mdu_op_o, resp_valid_o},
          {1'b1, 32'd100, 32'd7, MDU_DIVU, 2'b00});
      tick();
    end
    mdu_stall_i  = 1'b0;                      // T+33
    mdu_result_i = 32'd14;
    settle();
    chk("div_last_busy", {mdu_req_o, resp_valid_o}, 3'b100);
    tick();                                   // T+34
    mdu_result_i = 32'd0;
    settle();
    chk("div_resp_T34", {resp_valid_o, resp_result_o}, {2'b10, 32'd14});
    tick();
    $display("txn divu req1 100/7 -> %0d", resp_result_o);

    // ---------------- round robin ----------------
    set_req(0, 32'd3, 32'd5, MDU_MUL);
    set_req(1, 32'd4, 32'd9, MDU_MUL);
    req_valid_i = 2'b11;
    for (int g = 0; g < 4; g++) begin
      logic [NREQ-1:0] exp_oh;
      logic [XLEN-1:0] exp_res;
      exp_oh  = (g % 2 == 0) ? 2'b01 : 2'b10;
      exp_res = (g % 2 == 0) ? 32'd15 : 32'd36;
      settle();
      chk("rr_grant", req_ready_o, exp_oh);
      tick();                                 // BUSY
      mdu_result_i = exp_res;
      settle();
      chk("rr_busy", {req_ready_o, resp_valid_o, mdu_port_a_o},
          {2'b00, 2'b00, (g % 2 == 0) ? 32'd3 : 32'd4});
      tick();                                 // RESP
      settle();
      chk("rr_resp", {req_ready_o, resp_valid_o, resp_result_o}, {2'b00, exp_oh, exp_res});
      $display("txn rr grant %0d ready=%b resp=%b result=%0d", g, exp_oh, resp_valid_o, resp_result_o);
      tick();                                 // next IDLE
    end
    req_valid_i  = 2'b00;
    mdu_result_i = 32'd0;

    // ---------------- kill in flight ----------------
    set_req(0, 32'd50, 32'd5, MDU_DIVU);
    set_req(1, 32'd11, 32'd7, MDU_MUL);
    req_valid_i = 2'b11;
    mdu_stall_i = 1'b1;
    settle();
    chk("kill_accept0", req_ready_o, 2'b01);
    tick();
    req_valid_i = 2'b10;
    for (int c = 0; c < 4; c++) begin
      settle();
      chk("kill_prestall", {mdu_kill_o, mdu_req_o}, 2'b01);
      tick();
    end
    req_kill_i = 2'b01;                       // 5th stall cycle
    settle();
    chk("kill_pulse", {mdu_kill_o, resp_valid_o}, 3'b100);
    tick();
    req_kill_i  = 2'b00;
    mdu_stall_i = 1'b0;
    settle();
    chk("kill_idle_accept1", {busy_o, resp_valid_o, req_ready_o}, 5'b0_00_10);
    tick();
    req_valid_i  = 2'b00;
    mdu_result_i = 32'd77;
    settle();
    chk("kill_req1_port", {mdu_port_a_o, mdu_port_b_o}, {32'd11, 32'd7});
    tick();
    mdu_result_i = 32'd0;
    settle();
    chk("kill_req1_resp", {resp_valid_o, resp_result_o}, {2'b10, 32'd77});
    $display("txn kill req0 then req1 -> %0d", resp_result_o);
    tick();

    // ---------------- kill vs completion ----------------
    set_req(0, 32'd9, 32'd3, MDU_DIVU);
    req_valid_i = 2'b01;
    mdu_stall_i = 1'b1;
    settle();
    chk("kvc_accept", req_ready_o, 2'b01);
    tick();
    req_valid_i = 2'b00;
    tick();
    mdu_stall_i  = 1'b0;
    mdu_result_i = 32'd3;
    req_kill_i   = 2'b01;
    settle();
    chk("kvc_kill", mdu_kill_o, 1'b1);
    tick();
    req_kill_i   = 2'b00;
    mdu_result_i = 32'd0;
    settle();
    chk("kvc_noresp", {resp_valid_o, busy_o}, 3'b000);
    $display("txn kill-vs-complete req0 resp=%b", resp_valid_o);

    // ---------------- async reset during BUSY ----------------
    set_req(1, 32'd200, 32'd3, MDU_DIVU);
    req_valid_i = 2'b10;
    mdu_stall_i = 1'b1;
    settle();
    chk("ar_accept1", req_ready_o, 2'b10);
    tick();
    req_valid_i = 2'b00;
    tick();
    tick();
    settle();
    chk("ar_busy_before", {busy_o, mdu_req_o}, 2'b11);
    arstn_i = 1'b0;
    settle();
    chk("ar_immediate", {mdu_req_o, busy_o, resp_valid_o, mdu_port_a_o}, '0);
    set_req(0, 32'd1, 32'd2, MDU_MUL);
    req_valid_i = 2'b11;
    settle();
    chk("ar_ready_in_rst", req_ready_o, 2'b00);
    tick();
    arstn_i = 1'b1;
    settle();
    chk("ar_tie_req0", req_ready_o, 2'b01);
    $display("txn async reset, tie -> ready=%b", req_ready_o);
    tick();
    req_valid_i = 2'b00;
    settle();
    chk("ar_owner0_port", mdu_port_a_o, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
